hazard_scoreboard: RTL and testbench

Parametrised successor to the fixed 5-stage hazard unit of the pipelined RISC-V core. It self-tracks in-flight destination registers in a shadow E/M/W scoreboard, so the datapath no longer exports RD_M/RD_W/RS*_E. It adds a forwarding-disable mode, a variable-latency data-memory freeze and saturating stall/flush performance counters. It sits beside the datapath and controller and drives all stall, flush and forward-select signals.

---
 rtl/hazard_pkg.sv | 29 ++
 rtl/sb_stage_reg.sv | 35 +++
 rtl/hazard_scoreboard.sv | 151 +++++++++++++++
 tb/tb_hazard_scoreboard.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// Shared types for the hazard scoreboard: scoreboard entry layout, forward-select
// encoding and the "entry writes register r" predicate.
package hazard_pkg;

    // Register fields are stored at this fixed width; RAW must not exceed it.
    localparam int unsigned SB_AW = 8;

    typedef enum logic [1:0] {
        FWD_RF = 2'b00,
        FWD_W  = 2'b01,
        FWD_M  = 2'b10
    } fwd_sel_e;

    typedef struct packed {
        logic             valid;
        logic [SB_AW-1:0] rd;
        logic             regwrite;
        logic             is_load;
        logic [SB_AW-1:0] rs1;
        logic [SB_AW-1:0] rs2;
        logic             use_rs1;
        logic             use_rs2;
    } sb_entry_t;

    function automatic logic sb_writes(input sb_entry_t e, input logic [SB_AW-1:0] r);
        return e.valid & e.regwrite & (e.rd == r) & (r != '0);
    endfunction

endpackage

// File: rtl/sb_stage_reg.sv
// One scoreboard entry register: clr loads a bubble, en loads d, otherwise holds.
module sb_stage_reg
    import hazard_pkg::*;
(
    input  logic      clk,
    input  logic      rst,
    input  logic      en,
    input  logic      clr,
    input  sb_entry_t d,
    output sb_entry_t q
);

    sb_entry_t entry_d;
    sb_entry_t entry_q;

    always_comb begin
        entry_d = entry_q;
        if (clr) begin
            entry_d = '0;
        end else if (en) begin
            entry_d = d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            entry_q <= '0;
        end else begin
            entry_q <= entry_d;
        end
    end

    assign q = entry_q;

endmodule

// File: rtl/hazard_scoreboard.sv
// Hazard unit with a self-tracked E/M/W destination scoreboard: drives stalls,
// flushes, freeze and forward selects, and keeps saturating perf counters.
module hazard_scoreboard
    import hazard_pkg::*;
#(
    parameter int unsigned RAW    = 5,
    parameter int unsigned FWD_EN = 1,
    parameter int unsigned CNT_W  = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             valid_d,
    input  logic [RAW-1:0]   rs1_d,
    input  logic [RAW-1:0]   rs2_d,
    input  logic             use_rs1_d,
    input  logic             use_rs2_d,
    input  logic [RAW-1:0]   rd_d,
    input  logic             regwrite_d,
    input  logic             is_load_d,
    input  logic             redirect_e,
    input  logic             dmem_wait,
    output logic             stall_f,
    output logic             stall_d,
    output logic             flush_d,
    output logic             flush_e,
    output logic             freeze,
    output logic [1:0]       fwd_a_e,
    output logic [1:0]       fwd_b_e,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_events
);

    sb_entry_t        d_ent;
    sb_entry_t        e_q;
    sb_entry_t        m_q;
    sb_entry_t        w_q;
    logic [SB_AW-1:0] rs1_x;
    logic [SB_AW-1:0] rs2_x;
    logic             load_use;
    logic             raw_nofwd;
    logic             hz;
    fwd_sel_e         fwd_a;
    fwd_sel_e         fwd_b;
    logic [CNT_W-1:0] stall_cycles_d;
    logic [CNT_W-1:0] stall_cycles_q;
    logic [CNT_W-1:0] flush_events_d;
    logic [CNT_W-1:0] flush_events_q;

    assign freeze = dmem_wait;
    assign rs1_x  = SB_AW'(rs1_d);
    assign rs2_x  = SB_AW'(rs2_d);

    always_comb begin
        d_ent          = '0;
        d_ent.valid    = valid_d;
        d_ent.rd       = SB_AW'(rd_d);
        d_ent.regwrite = regwrite_d;
        d_ent.is_load  = is_load_d;
        d_ent.rs1      = rs1_x;
        d_ent.rs2      = rs2_x;
        d_ent.use_rs1  = use_rs1_d;
        d_ent.use_rs2  = use_rs2_d;
    end

    // Freeze holds E and M while W takes a bubble.
    sb_stage_reg u_sb_e (.clk(clk), .rst(rst), .en(~freeze), .clr(flush_e), .d(d_ent), .q(e_q));
    sb_stage_reg u_sb_m (.clk(clk), .rst(rst), .en(~freeze), .clr(1'b0),    .d(e_q),   .q(m_q));
    sb_stage_reg u_sb_w (.clk(clk), .rst(rst), .en(1'b1),    .clr(freeze),  .d(m_q),   .q(w_q));

    always_comb begin
        load_use  = valid_d & e_q.is_load &
                    ((use_rs1_d & sb_writes(e_q, rs1_x)) | (use_rs2_d & sb_writes(e_q, rs2_x)));
        raw_nofwd = valid_d &
                    ((use_rs1_d & (sb_writes(e_q, rs1_x) | sb_writes(m_q, rs1_x))) |
                     (use_rs2_d & (sb_writes(e_q, rs2_x) | sb_writes(m_q, rs2_x))));
        hz = load_use;
        if (FWD_EN == 0) begin
            hz = load_use | raw_nofwd;
        end
    end

    always_comb begin
        stall_f = 1'b0;
        stall_d = 1'b0;
        flush_d = 1'b0;
        flush_e = 1'b0;
        if (freeze) begin
            stall_f = 1'b1;
            stall_d = 1'b1;
        end else if (redirect_e) begin
            flush_d = 1'b1;
            flush_e = 1'b1;
        end else if (hz) begin
            stall_f = 1'b1;
            stall_d = 1'b1;
            flush_e = 1'b1;
        end
    end

    // A load in M is skipped so its register falls through to the W check.
    function automatic fwd_sel_e pick_fwd(input logic use_rs, input logic [SB_AW-1:0] r,
                                          input sb_entry_t m, input sb_entry_t w);
        if (use_rs & sb_writes(m, r) & ~m.is_load) begin
            return FWD_M;
        end else if (use_rs & sb_writes(w, r)) begin
            return FWD_W;
        end
        return FWD_RF;
    endfunction

    always_comb begin
        fwd_a = FWD_RF;
        fwd_b = FWD_RF;
        if (FWD_EN != 0) begin
            fwd_a = pick_fwd(e_q.use_rs1, e_q.rs1, m_q, w_q);
            fwd_b = pick_fwd(e_q.use_rs2, e_q.rs2, m_q, w_q);
        end
    end

    assign fwd_a_e = fwd_a;
    assign fwd_b_e = fwd_b;

    always_comb begin
        stall_cycles_d = stall_cycles_q;
        flush_events_d = flush_events_q;
        if (stall_d && (stall_cycles_q != '1)) begin
            stall_cycles_d = stall_cycles_q + CNT_W'(1);
        end
        if (redirect_e && !freeze && (flush_events_q != '1)) begin
            flush_events_d = flush_events_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cycles_q <= '0;
            flush_events_q <= '0;
        end else begin
            stall_cycles_q <= stall_cycles_d;
            flush_events_q <= flush_events_d;
        end
    end

    assign stall_cycles = stall_cycles_q;
    assign flush_events = flush_events_q;

    logic unused_fields;
    assign unused_fields = ^{m_q.rs1, m_q.rs2, m_q.use_rs1, m_q.use_rs2,
                             w_q.rs1, w_q.rs2, w_q.use_rs1, w_q.use_rs2, w_q.is_load};

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Bench for hazard_scoreboard: two instances (forwarding on/off) share stimulus;
// a reference pipeline model queues expected outputs and a monitor compares them.
module tb_hazard_scoreboard;

    localparam int RAW  = 5;
    localparam int CNTW = 4;
    localparam int CMAX = (1 << CNTW) - 1;

    logic           clk = 1'b0;
    logic           rst;
    logic           valid_d, use_rs1_d, use_rs2_d, regwrite_d, is_load_d, redirect_e, dmem_wait;
    logic [RAW-1:0] rs1_d, rs2_d, rd_d;

    logic            sf_o [2];
    logic            sd_o [2];
    logic            fd_o [2];
    logic            fe_o [2];
    logic            fz_o [2];
    logic [1:0]      fa_o [2];
    logic [1:0]      fb_o [2];
    logic [CNTW-1:0] sc_o [2];
    logic [CNTW-1:0] fc_o [2];

    always #5 clk = ~clk;

    // Index 1: forwarding enabled; index 0: forwarding disabled.
    hazard_scoreboard #(.RAW(RAW), .FWD_EN(1), .CNT_W(CNTW)) dut_fwd (
        .clk(clk), .rst(rst), .valid_d(valid_d), .rs1_d(rs1_d), .rs2_d(rs2_d),
        .use_rs1_d(use_rs1_d), .use_rs2_d(use_rs2_d), .rd_d(rd_d), .regwrite_d(regwrite_d),
        .is_load_d(is_load_d), .redirect_e(redirect_e), .dmem_wait(dmem_wait),
        .stall_f(sf_o[1]), .stall_d(sd_o[1]), .flush_d(fd_o[1]), .flush_e(fe_o[1]),
        .freeze(fz_o[1]), .fwd_a_e(fa_o[1]), .fwd_b_e(fb_o[1]),
        .stall_cycles(sc_o[1]), .flush_events(fc_o[1]));

    hazard_scoreboard #(.RAW(RAW), .FWD_EN(0), .CNT_W(CNTW)) dut_nofwd (
        .clk(clk), .rst(rst), .valid_d(valid_d), .rs1_d(rs1_d), .rs2_d(rs2_d),
        .use_rs1_d(use_rs1_d), .use_rs2_d(use_rs2_d), .rd_d(rd_d), .regwrite_d(regwrite_d),
        .is_load_d(is_load_d), .redirect_e(redirect_e), .dmem_wait(dmem_wait),
        .stall_f(sf_o[0]), .stall_d(sd_o[0]), .flush_d(fd_o[0]), .flush_e(fe_o[0]),
        .freeze(fz_o[0]), .fwd_a_e(fa_o[0]), .fwd_b_e(fb_o[0]),
        .stall_cycles(sc_o[0]), .flush_events(fc_o[0]));

    typedef struct {
        bit v; int rd; bit wr; bit ld; int rs1; int rs2; bit u1; bit u2;
    } ins_t;

    typedef struct {
        int dut; int sf; int sd; int fd; int fe; int fz; int fa; int fb; int sc; int fc;
    } exp_t;

    ins_t pipe [2][3];   // [variant][0=E,1=M,2=W]
    int   sc_m [2];
    int   fc_m [2];
    exp_t expq [$];
    int   total = 0;
    int   bad   = 0;

    function automatic bit produces(ins_t i, int r);
        return i.v && i.wr && (i.rd == r) && (r != 0);
    endfunction

    // Youngest non-load producer in M wins, then W, else register file.
    function automatic int fwd_ref(int f, bit u, int r, ins_t m, ins_t w);
        if (f == 0 || !u) return 0;
        if (produces(m, r) && !m.ld) return 2;
        if (produces(w, r)) return 1;
        return 0;
    endfunction

    task automatic cyc(input bit r, input bit v, input int a, input int b, input bit ua,
                       input bit ub, input int d, input bit w, input bit l, input bit rdr,
                       input bit dw);
        ins_t din;
        ins_t bub;
        exp_t x;
        bit   lu, raw, hz;
        @(negedge clk);
        rst = r; valid_d = v; rs1_d = RAW'(a); rs2_d = RAW'(b); use_rs1_d = ua;
        use_rs2_d = ub; rd_d = RAW'(d); regwrite_d = w; is_load_d = l;
        redirect_e = rdr; dmem_wait = dw;
        bub = '{default: 0};
        din = '{v: v, rd: d, wr: w, ld: l, rs1: a, rs2: b, u1: ua, u2: ub};
        for (int f = 0; f < 2; f++) begin
            if (r) begin
                for (int k = 0; k < 3; k++) pipe[f][k] = bub;
                sc_m[f] = 0;
                fc_m[f] = 0;
            end
            lu = v && pipe[f][0].ld &&
                 ((ua && produces(pipe[f][0], a)) || (ub && produces(pipe[f][0], b)));
            raw = 0;
            for (int k = 0; k < 2; k++)
                raw |= v && ((ua && produces(pipe[f][k], a)) || (ub && produces(pipe[f][k], b)));
            hz = lu || (f == 0 && raw);
            x = '{default: 0};
            x.dut = f;
            x.fz  = dw;
            if (dw) begin
                x.sf = 1; x.sd = 1;
            end else if (rdr) begin
                x.fd = 1; x.fe = 1;
            end else if (hz) begin
                x.sf = 1; x.sd = 1; x.fe = 1;
            end
            x.fa = fwd_ref(f, pipe[f][0].u1, pipe[f][0].rs1, pipe[f][1], pipe[f][2]);
            x.fb = fwd_ref(f, pipe[f][0].u2, pipe[f][0].rs2, pipe[f][1], pipe[f][2]);
            x.sc = sc_m[f];
            x.fc = fc_m[f];
            expq.push_back(x);
            if (!r) begin
                sc_m[f] = (sc_m[f] + x.sd > CMAX) ? CMAX : sc_m[f] + x.sd;
                if (rdr && !dw) fc_m[f] = (fc_m[f] + 1 > CMAX) ? CMAX : fc_m[f] + 1;
                if (dw) begin
                    pipe[f][2] = bub;
                end else begin
                    pipe[f][2] = pipe[f][1];
                    pipe[f][1] = pipe[f][0];
                    pipe[f][0] = x.fe ? bub : din;
                end
            end
        end
    endtask

    task automatic nop(input int n);
        for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic chk(input string name, input int dut, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s dut%0d at %0t: got %0d want %0d", name, dut, $time, act, req);
        end
    endtask

    initial begin
        exp_t x;
        forever begin
            @(negedge clk);
            #2;
            while (expq.size() > 0) begin
                x = expq.pop_front();
                chk("stall_f", x.dut, int'(sf_o[x.dut]), x.sf);
                chk("stall_d", x.dut, int'(sd_o[x.dut]), x.sd);
                chk("flush_d", x.dut, int'(fd_o[x.dut]), x.fd);
                chk("flush_e", x.dut, int'(fe_o[x.dut]), x.fe);
                chk("freeze", x.dut, int'(fz_o[x.dut]), x.fz);
                chk("fwd_a_e", x.dut, int'(fa_o[x.dut]), x.fa);
                chk("fwd_b_e", x.dut, int'(fb_o[x.dut]), x.fb);
                chk("stall_cycles", x.dut, int'(sc_o[x.dut]), x.sc);
                chk("flush_events", x.dut, int'(fc_o[x.dut]), x.fc);
            end
        end
    end

    initial begin
        rst = 1'b1; valid_d = 0; use_rs1_d = 0; use_rs2_d = 0; regwrite_d = 0;
        is_load_d = 0; redirect_e = 0; dmem_wait = 0; rs1_d = '0; rs2_d = '0; rd_d = '0;
        cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        nop(1);
        // lw x5 ; add x6,x5,x1 (add held in D while stalled)
        cyc(0, 1, 2, 0, 1, 0, 5, 1, 1, 0, 0);
        cyc(0, 1, 5, 1, 1, 1, 6, 1, 0, 0, 0);
        cyc(0, 1, 5, 1, 1, 1, 6, 1, 0, 0, 0);
        cyc(0, 1, 5, 1, 1, 1, 6, 1, 0, 0, 0);
        nop(3);
        // add x5 ; sub x7,x5,x5
        cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        cyc(0, 1, 1, 2, 1, 1, 5, 1, 0, 0, 0);
        cyc(0, 1, 5, 5, 1, 1, 7, 1, 0, 0, 0);
        cyc(0, 1, 5, 5, 1, 1, 7, 1, 0, 0, 0);
        cyc(0, 1, 5, 5, 1, 1, 7, 1, 0, 0, 0);
        nop(3);
        // lw x0 ; consumer of x0
        cyc(0, 1, 1, 0, 1, 0, 0, 1, 1, 0, 0);
        cyc(0, 1, 0, 0, 1, 1, 8, 1, 0, 0, 0);
        nop(3);
        // redirect coinciding with load-use
        cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        cyc(0, 1, 2, 0, 1, 0, 5, 1, 1, 0, 0);
        cyc(0, 1, 5, 0, 1, 0, 6, 1, 0, 1, 0);
        nop(2);
        // redirect held through a 3-cycle freeze, then back-to-back redirects
        cyc(0, 1, 1, 1, 1, 1, 3, 1, 0, 0, 0);
        for (int i = 0; i < 3; i++) cyc(0, 1, 3, 0, 1, 0, 4, 1, 0, 1, 1);
        cyc(0, 1, 3, 0, 1, 0, 4, 1, 0, 1, 0);
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        nop(1);
        cyc(1, 1, 1, 2, 1, 1, 3, 1, 0, 0, 0);
        nop(2);
        for (int i = 0; i < 800; i++) begin
            cyc(($urandom_range(0, 99) == 0), ($urandom_range(0, 3) != 0),
                int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
                $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
                int'($urandom_range(0, 7)), $urandom_range(0, 3) != 0,
                $urandom_range(0, 2) == 0, $urandom_range(0, 9) == 0,
                $urandom_range(0, 6) == 0);
        end
        nop(1);
        repeat (3) @(negedge clk);
        #3;
        chk("queue_drained", 0, expq.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
